icache_refill_ctrl: RTL and testbench
=====================================

# icache_refill_ctrl

Miss handler and refill sequencer for the instruction cache. Accepts a single outstanding fetch miss, issues a line-aligned request to the memory side, assembles the returned beats into a full line, and writes tag and data into a round-robin victim way of the indexed set. Sits between the fetch stage (miss source), the memory interface, and the instruction cache tag/data arrays (fill port).

## Interface
- ASSOC, 4: ways per set; power of two, at least 2
- ADDR_W, 32: fetch address width
- INDEX_W, 6: set index bits
- BEAT_W, 32: memory response beat width
- LINE_BEATS, 8: beats per line; power of two. OFFSET_W = log2(LINE_BEATS*BEAT_W/8); TAG_W = ADDR_W-INDEX_W-OFFSET_W

- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_miss_valid  in  1  fetch reports a miss
- i_miss_addr  in  ADDR_W  miss address, any byte offset
- o_miss_ready  out  1  miss accepted this cycle when valid&ready
- i_abort  in  1  fetch redirect; cancels the current refill
- o_mem_req_valid  out  1  line request valid
- o_mem_req_addr  out  ADDR_W  line-aligned address (offset bits zero)
- i_mem_req_ready  in  1  memory accepts request
- i_mem_resp_valid  in  1  one beat valid
- i_mem_resp_data  in  BEAT_W  beat payload, beats in ascending address order
- o_fill_we  out  1  one-cycle write strobe to tag/data arrays
- o_fill_way  out  log2(ASSOC)  victim way
- o_fill_index  out  INDEX_W  set index
- o_fill_tag  out  TAG_W  tag; valid bit implied set
- o_fill_data  out  LINE_BEATS*BEAT_W  line, beat 0 in least significant bits
- o_busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, REQ, FILL, DRAIN, WRITE.
- IDLE: o_miss_ready=1. On i_miss_valid, latch address, go to REQ. i_abort in the same cycle wins: no latch, stay IDLE.
- REQ: o_mem_req_valid=1 with the latched line address, held stable until i_mem_req_ready. On handshake go to FILL with beat counter 0. i_abort before handshake: go to IDLE and issue no request. i_abort coincident with handshake: go to DRAIN.
- FILL: each i_mem_resp_valid stores the beat at the counter position and increments the counter. On the final beat (counter = LINE_BEATS-1) go to WRITE. i_abort: go to DRAIN; a beat arriving in the abort cycle is counted.
- DRAIN: count remaining beats and discard them; after the last beat go to IDLE with no fill write. i_abort is ignored.
- WRITE: o_fill_we=1 for exactly one cycle. Way = victim pointer. Victim pointer then increments modulo ASSOC. Next state is IDLE. i_abort is ignored because the line is already complete.
- i_mem_resp_valid in IDLE, REQ or WRITE is ignored.
- The beat counter is log2(LINE_BEATS) bits and wraps to 0 after the last beat.

## Timing
- Reset: state IDLE, counter 0, victim pointer 0, latched address 0, line buffer 0. All outputs are 0 except o_miss_ready=1. Reset applies mid-refill with no write and no request.
- Miss accepted in cycle N gives o_mem_req_valid in cycle N+1.
- Last beat in cycle M gives o_fill_we in cycle M+1, with o_miss_ready=1 in M+2.
- Minimum miss-to-next-accept is LINE_BEATS+3 cycles with zero memory wait.
- o_fill_* are registered. Index, tag and data are stable from the cycle after the last beat through WRITE.
- Memory returns exactly LINE_BEATS beats per accepted request.

## Structure
- Shared package icache_pkg holds ASSOC, INDEX_W, LINE_BEATS, BEAT_W, the derived OFFSET_W and TAG_W, the icache_fill_t struct (way, index, tag, data), and the refill state enum.
- Sub-module icache_fill_buffer holds the beat counter and line assembly register. Its interface: clear, beat valid/data, last-beat flag, line out.
- The FSM and victim pointer stay in the top module.

## Test plan
- Basic refill: miss 0x0000_1234, ready immediate, beats 0x11..0x88 -> o_mem_req_addr=0x0000_1220. The index and tag are derived from the address split; with defaults, index=0x11 and tag=0x0000_1234>>11. fill_we one cycle after beat 8, data LSB beat 0x11, way 0.
- Round-robin: five consecutive refills with ASSOC=4 -> ways 0,1,2,3,0.
- Backpressure: i_mem_req_ready low 5 cycles -> request address held stable, exactly one handshake.
- Abort in FILL after 3 beats -> remaining 5 beats absorbed, no fill_we, victim pointer unchanged, o_miss_ready returns after the 8th beat.
- Abort in REQ before ready -> IDLE next cycle, no request handshake; a new miss is accepted immediately.
- Async reset asserted mid-FILL between clock edges -> outputs at reset values before the next edge, no fill_we, next refill uses way 0.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared configuration for the instruction-cache refill path.
//   Geometry   : ASSOC, ADDR_W, INDEX_W, BEAT_W, LINE_BEATS and the derived
//                OFFSET_W / TAG_W / WAY_W / BEAT_CNT_W / LINE_W.
//   Types      : refill_state_e (refill FSM), icache_fill_t (fill-port bundle).
//   Helper     : line_align() clears the byte-offset bits of an address.
package icache_pkg;

    localparam int ASSOC      = 4;
    localparam int ADDR_W     = 32;
    localparam int INDEX_W    = 6;
    localparam int BEAT_W     = 32;
    localparam int LINE_BEATS = 8;

    localparam int WAY_W      = $clog2(ASSOC);
    localparam int BEAT_CNT_W = $clog2(LINE_BEATS);
    localparam int LINE_W     = LINE_BEATS * BEAT_W;
    localparam int OFFSET_W   = $clog2(LINE_W / 8);
    localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LADDR_W    = ADDR_W - OFFSET_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_FILL,
        ST_DRAIN,
        ST_WRITE
    } refill_state_e;

    typedef struct packed {
        logic [WAY_W-1:0]   way;
        logic [INDEX_W-1:0] index;
        logic [TAG_W-1:0]   tag;
        logic [LINE_W-1:0]  data;
    } icache_fill_t;

    function automatic logic [ADDR_W-1:0] line_align(input logic [LADDR_W-1:0] laddr);
        return {laddr, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/icache_fill_buffer.sv
// icache_fill_buffer: beat counter and line assembly register for a refill.
//   i_clk, i_rst    : clock, asynchronous active-high reset
//   i_clear         : restart the beat counter at 0 (new request accepted)
//   i_beat_valid    : a response beat is present and must be counted
//   i_store         : write the counted beat into the line (low while draining)
//   i_beat_data     : beat payload
//   o_last          : the beat presented this cycle is the final beat of the line
//   o_line          : assembled line, beat 0 in the least significant bits
module icache_fill_buffer
    import icache_pkg::*;
#(
    parameter int BW = BEAT_W,
    parameter int NB = LINE_BEATS
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_beat_valid,
    input  logic             i_store,
    input  logic [BW-1:0]    i_beat_data,
    output logic             o_last,
    output logic [NB*BW-1:0] o_line
);

    localparam int CW = $clog2(NB);
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NB-1:0][BW-1:0]  line_q;

    // Counter is log2(NB) bits so it wraps to 0 on its own after the last beat.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear)
            cnt_d = '0;
        else if (i_beat_valid)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    for (genvar g = 0; g < NB; g++) begin : g_beat
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst)
                line_q[g] <= '0;
            else if (i_store && i_beat_valid && (cnt_q == CW'(g)))
                line_q[g] <= i_beat_data;
        end
    end

    assign o_last = i_beat_valid && (cnt_q == LAST);
    assign o_line = line_q;

endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: single-outstanding I-cache miss handler and refill sequencer.
//   Miss side  : i_miss_valid/i_miss_addr/o_miss_ready, i_abort (fetch redirect)
//   Memory req : o_mem_req_valid/o_mem_req_addr (line aligned)/i_mem_req_ready
//   Memory resp: i_mem_resp_valid/i_mem_resp_data, LINE_BEATS beats ascending
//   Fill port  : o_fill_we (one-cycle strobe), o_fill_way/index/tag/data
//   Status     : o_busy, high in every state except IDLE
// All outputs come straight from registers.
module icache_refill_ctrl
    import icache_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_miss_valid,
    input  logic [ADDR_W-1:0]  i_miss_addr,
    output logic               o_miss_ready,
    input  logic               i_abort,
    output logic               o_mem_req_valid,
    output logic [ADDR_W-1:0]  o_mem_req_addr,
    input  logic               i_mem_req_ready,
    input  logic               i_mem_resp_valid,
    input  logic [BEAT_W-1:0]  i_mem_resp_data,
    output logic               o_fill_we,
    output logic [WAY_W-1:0]   o_fill_way,
    output logic [INDEX_W-1:0] o_fill_index,
    output logic [TAG_W-1:0]   o_fill_tag,
    output logic [LINE_W-1:0]  o_fill_data,
    output logic               o_busy
);

    refill_state_e       state_q;
    logic [LADDR_W-1:0]  laddr_q;
    logic [WAY_W-1:0]    victim_q;
    logic                miss_ready_q;
    logic                req_valid_q;
    logic                fill_we_q;
    logic                busy_q;

    logic                buf_clear;
    logic                buf_valid;
    logic                buf_store;
    logic                beat_last;
    logic [LINE_W-1:0]   line;
    icache_fill_t        fill;

    // Byte-offset bits of the miss address never matter: the line is refilled whole.
    logic                unused_offset;
    assign unused_offset = ^i_miss_addr[OFFSET_W-1:0];

    // Beats are counted in FILL and DRAIN but only kept in FILL.
    assign buf_clear = (state_q == ST_REQ) && i_mem_req_ready;
    assign buf_valid = i_mem_resp_valid && ((state_q == ST_FILL) || (state_q == ST_DRAIN));
    assign buf_store = (state_q == ST_FILL);

    icache_fill_buffer u_buf (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (buf_clear),
        .i_beat_valid (buf_valid),
        .i_store      (buf_store),
        .i_beat_data  (i_mem_resp_data),
        .o_last       (beat_last),
        .o_line       (line)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            laddr_q      <= '0;
            victim_q     <= '0;
            miss_ready_q <= 1'b1;
            req_valid_q  <= 1'b0;
            fill_we_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            fill_we_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    // A redirect in the same cycle kills the miss before it is latched.
                    if (i_miss_valid && !i_abort) begin
                        laddr_q      <= i_miss_addr[ADDR_W-1:OFFSET_W];
                        state_q      <= ST_REQ;
                        miss_ready_q <= 1'b0;
                        req_valid_q  <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (i_mem_req_ready) begin
                        // Once the request is out, its beats must be absorbed even if aborted.
                        req_valid_q <= 1'b0;
                        state_q     <= i_abort ? ST_DRAIN : ST_FILL;
                    end else if (i_abort) begin
                        req_valid_q  <= 1'b0;
                        miss_ready_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (beat_last) begin
                        // Abort on the final beat: nothing left to drain, drop the line.
                        if (i_abort) begin
                            miss_ready_q <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= ST_IDLE;
                        end else begin
                            fill_we_q <= 1'b1;
                            state_q   <= ST_WRITE;
                        end
                    end else if (i_abort) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (beat_last) begin
                        miss_ready_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    victim_q     <= victim_q + 1'b1;
                    miss_ready_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    req_valid_q  <= 1'b0;
                    miss_ready_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    // Fill fields are all register outputs; they hold from the cycle after the
    // last beat through WRITE because nothing updates them in between.
    assign fill.way   = victim_q;
    assign fill.index = laddr_q[INDEX_W-1:0];
    assign fill.tag   = laddr_q[LADDR_W-1:INDEX_W];
    assign fill.data  = line;

    assign o_miss_ready    = miss_ready_q;
    assign o_mem_req_valid = req_valid_q;
    assign o_mem_req_addr  = line_align(laddr_q);
    assign o_fill_we       = fill_we_q;
    assign o_fill_way      = fill.way;
    assign o_fill_index    = fill.index;
    assign o_fill_tag      = fill.tag;
    assign o_fill_data     = fill.data;
    assign o_busy          = busy_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
module tb_icache_refill_ctrl;
    import icache_pkg::*;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_miss_valid;
    logic [ADDR_W-1:0]  i_miss_addr;
    logic               o_miss_ready;
    logic               i_abort;
    logic               o_mem_req_valid;
    logic [ADDR_W-1:0]  o_mem_req_addr;
    logic               i_mem_req_ready;
    logic               i_mem_resp_valid;
    logic [BEAT_W-1:0]  i_mem_resp_data;
    logic               o_fill_we;
    logic [WAY_W-1:0]   o_fill_way;
    logic [INDEX_W-1:0] o_fill_index;
    logic [TAG_W-1:0]   o_fill_tag;
    logic [LINE_W-1:0]  o_fill_data;
    logic               o_busy;

    always #5 i_clk = ~i_clk;

    icache_refill_ctrl dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_miss_valid     (i_miss_valid),
        .i_miss_addr      (i_miss_addr),
        .o_miss_ready     (o_miss_ready),
        .i_abort          (i_abort),
        .o_mem_req_valid  (o_mem_req_valid),
        .o_mem_req_addr   (o_mem_req_addr),
        .i_mem_req_ready  (i_mem_req_ready),
        .i_mem_resp_valid (i_mem_resp_valid),
        .i_mem_resp_data  (i_mem_resp_data),
        .o_fill_we        (o_fill_we),
        .o_fill_way       (o_fill_way),
        .o_fill_index     (o_fill_index),
        .o_fill_tag       (o_fill_tag),
        .o_fill_data      (o_fill_data),
        .o_busy           (o_busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] beat_base;
        int          wait_n;
        int          exp_way;
        logic [31:0] exp_req;
    } vec_t;

    int vec_cnt  = 0;
    int err_cnt  = 0;
    int hs_cnt   = 0;
    int fill_cnt = 0;
    int exp_fills = 0;
    icache_fill_t exp_q[$];
    vec_t vecs[5];

    // Observed request handshakes and fill strobes, sampled mid-cycle.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_mem_req_valid && i_mem_req_ready) hs_cnt++;
            if (o_fill_we) fill_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // Index = addr[10:5], tag = addr[31:11] for 32-byte lines and 64 sets.
    function automatic icache_fill_t mk_exp(input logic [31:0] addr, input logic [31:0] base, input int way);
        icache_fill_t e;
        e.way   = WAY_W'(way);
        e.index = INDEX_W'((addr >> 5) & 32'h3f);
        e.tag   = TAG_W'(addr >> 11);
        for (int b = 0; b < 8; b++) e.data[b*32 +: 32] = base + 32'(b) * 32'h11;
        return e;
    endfunction

    task automatic send_beats(input logic [31:0] base, input int first, input int n);
        for (int b = first; b < first + n; b++) begin
            i_mem_resp_valid = 1'b1;
            i_mem_resp_data  = base + 32'(b) * 32'h11;
            tick();
        end
        i_mem_resp_valid = 1'b0;
        i_mem_resp_data  = '0;
    endtask

    task automatic check_fill;
        icache_fill_t e;
        if (exp_q.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL sb_unexpected_fill: got fill_we with no expected entry, expected none");
        end else begin
            e = exp_q.pop_front();
            chk("fill_way",   LINE_W'(o_fill_way),   LINE_W'(e.way));
            chk("fill_index", LINE_W'(o_fill_index), LINE_W'(e.index));
            chk("fill_tag",   LINE_W'(o_fill_tag),   LINE_W'(e.tag));
            chk("fill_data",  o_fill_data,           e.data);
        end
    endtask

    task automatic refill(input vec_t v);
        int hs0;
        hs0 = hs_cnt;
        chk("idle_ready", LINE_W'(o_miss_ready), 1);
        i_miss_valid = 1'b1;
        i_miss_addr  = v.addr;
        tick();
        i_miss_valid = 1'b0;
        i_miss_addr  = '0;
        chk("req_valid",  LINE_W'(o_mem_req_valid), 1);
        chk("req_addr",   LINE_W'(o_mem_req_addr), LINE_W'(v.exp_req));
        chk("ready_low",  LINE_W'(o_miss_ready), 0);
        for (int w = 0; w < v.wait_n; w++) begin
            tick();
            chk("req_hold_valid", LINE_W'(o_mem_req_valid), 1);
            chk("req_hold_addr",  LINE_W'(o_mem_req_addr), LINE_W'(v.exp_req));
        end
        i_mem_req_ready = 1'b1;
        tick();
        i_mem_req_ready = 1'b0;
        chk("req_drop", LINE_W'(o_mem_req_valid), 0);
        exp_q.push_back(mk_exp(v.addr, v.beat_base, v.exp_way));
        exp_fills++;
        send_beats(v.beat_base, 0, 8);
        chk("fill_we", LINE_W'(o_fill_we), 1);
        if (o_fill_we) check_fill();
        tick();
        chk("fill_we_pulse", LINE_W'(o_fill_we), 0);
        chk("ready_back",    LINE_W'(o_miss_ready), 1);
        chk("one_handshake", LINE_W'(hs_cnt - hs0), 1);
    endtask

    initial begin
        int hs0;
        int f0;
        vec_t v;

        vecs[0] = '{32'h0000_1234, 32'h0000_0011, 0, 0, 32'h0000_1220};
        vecs[1] = '{32'hDEAD_BEEF, 32'h0000_0100, 0, 1, 32'hDEAD_BEE0};
        vecs[2] = '{32'h0000_07FF, 32'hA5A5_0000, 5, 2, 32'h0000_07E0};
        vecs[3] = '{32'hFFFF_FFE0, 32'h0000_0001, 2, 3, 32'hFFFF_FFE0};
        vecs[4] = '{32'h8000_0010, 32'h0000_5000, 0, 0, 32'h8000_0000};

        i_rst = 1'b1;
        i_miss_valid = 1'b0;
        i_miss_addr = '0;
        i_abort = 1'b0;
        i_mem_req_ready = 1'b0;
        i_mem_resp_valid = 1'b0;
        i_mem_resp_data = '0;
        tick();
        tick();
        chk("rst_miss_ready", LINE_W'(o_miss_ready), 1);
        chk("rst_req_valid",  LINE_W'(o_mem_req_valid), 0);
        chk("rst_req_addr",   LINE_W'(o_mem_req_addr), 0);
        chk("rst_fill_we",    LINE_W'(o_fill_we), 0);
        chk("rst_busy",       LINE_W'(o_busy), 0);
        chk("rst_fill_data",  o_fill_data, 0);
        i_rst = 1'b0;
        tick();

        // Table: basic refill, round robin 0,1,2,3,0, request backpressure.
        for (int i = 0; i < 5; i++) refill(vecs[i]);

        // Abort in FILL after 3 beats: remaining 5 beats drained, no write.
        f0 = fill_cnt;
        i_miss_valid = 1'b1; i_miss_addr = 32'h0000_4440;
        tick();
        i_miss_valid = 1'b0;
        i_mem_req_ready = 1'b1;
        tick();
        i_mem_req_ready = 1'b0;
        send_beats(32'h7000_0000, 0, 3);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("fabort_busy", LINE_W'(o_busy), 1);
        send_beats(32'h7000_0000, 3, 4);
        chk("fabort_draining", LINE_W'(o_miss_ready), 0);
        send_beats(32'h7000_0000, 7, 1);
        chk("fabort_ready", LINE_W'(o_miss_ready), 1);
        chk("fabort_idle",  LINE_W'(o_busy), 0);
        chk("fabort_nowrite", LINE_W'(fill_cnt - f0), 0);
        v = '{32'h0001_0000, 32'h0000_0300, 0, 1, 32'h0001_0000};
        refill(v);

        // Abort coincident with a miss in IDLE: miss is not taken.
        i_miss_valid = 1'b1; i_miss_addr = 32'h0000_5555; i_abort = 1'b1;
        tick();
        i_miss_valid = 1'b0; i_abort = 1'b0;
        chk("iabort_ready", LINE_W'(o_miss_ready), 1);
        chk("iabort_noreq", LINE_W'(o_mem_req_valid), 0);
        chk("iabort_busy",  LINE_W'(o_busy), 0);

        // Abort in REQ before ready: back to IDLE, no handshake, next miss accepted at once.
        hs0 = hs_cnt;
        i_miss_valid = 1'b1; i_miss_addr = 32'h0000_6660;
        tick();
        i_miss_valid = 1'b0;
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("rabort_noreq", LINE_W'(o_mem_req_valid), 0);
        chk("rabort_ready", LINE_W'(o_miss_ready), 1);
        chk("rabort_nohs",  LINE_W'(hs_cnt - hs0), 0);
        v = '{32'h0002_0040, 32'h0000_0400, 1, 2, 32'h0002_0040};
        refill(v);

        // Async reset mid-FILL, between clock edges.
        f0 = fill_cnt;
        i_miss_valid = 1'b1; i_miss_addr = 32'h0003_0000;
        tick();
        i_miss_valid = 1'b0;
        i_mem_req_ready = 1'b1;
        tick();
        i_mem_req_ready = 1'b0;
        send_beats(32'h0000_0900, 0, 3);
        #2;
        i_rst = 1'b1;
        #1;
        chk("arst_ready",   LINE_W'(o_miss_ready), 1);
        chk("arst_busy",    LINE_W'(o_busy), 0);
        chk("arst_req",     LINE_W'(o_mem_req_valid), 0);
        chk("arst_fill_we", LINE_W'(o_fill_we), 0);
        chk("arst_way",     LINE_W'(o_fill_way), 0);
        chk("arst_data",    o_fill_data, 0);
        tick();
        i_rst = 1'b0;
        tick();
        chk("arst_nowrite", LINE_W'(fill_cnt - f0), 0);
        v = '{32'h0004_0020, 32'h0000_0500, 0, 0, 32'h0004_0020};
        refill(v);

        // Abort coincident with the request handshake: all 8 beats drained.
        hs0 = hs_cnt;
        f0 = fill_cnt;
        i_miss_valid = 1'b1; i_miss_addr = 32'h0005_0000;
        tick();
        i_miss_valid = 1'b0;
        i_mem_req_ready = 1'b1; i_abort = 1'b1;
        tick();
        i_mem_req_ready = 1'b0; i_abort = 1'b0;
        chk("habort_noreq", LINE_W'(o_mem_req_valid), 0);
        chk("habort_busy",  LINE_W'(o_busy), 1);
        chk("habort_hs",    LINE_W'(hs_cnt - hs0), 1);
        send_beats(32'h0000_0a00, 0, 7);
        chk("habort_draining", LINE_W'(o_miss_ready), 0);
        send_beats(32'h0000_0a00, 7, 1);
        chk("habort_ready",   LINE_W'(o_miss_ready), 1);
        chk("habort_nowrite", LINE_W'(fill_cnt - f0), 0);
        v = '{32'h0006_07C0, 32'h0000_0600, 0, 1, 32'h0006_07C0};
        refill(v);

        chk("sb_empty",   LINE_W'(exp_q.size()), 0);
        chk("fill_total", LINE_W'(fill_cnt), LINE_W'(exp_fills));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
